// File: rtl/comp_arb_ctrl.sv
// Round-robin arbiter/sequencer sharing one equality comparator among NREQ requesters.
// Optional COMP_ARB_STATS_EN adds compare/match counters with a synchronous clear.
module comp_arb_ctrl #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] a_in,
   input  logic [NREQ*WIDTH-1:0] b_in,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic                  match,
   output logic [WIDTH-1:0]      cmp_a,
   output logic [WIDTH-1:0]      cmp_b,
   input  logic                  cmp_eq,
   output logic                  busy
`ifdef COMP_ARB_STATS_EN
   ,
   input  logic                  stats_clr,
   output logic [15:0]           cmp_cnt,
   output logic [15:0]           match_cnt
`endif
);

   localparam int PW = $clog2(NREQ);

   typedef enum logic {IDLE, EVAL} state_t;

   state_t           state, state_nxt;
   logic [PW-1:0]    rr_ptr, rr_nxt;
   logic [PW-1:0]    win, cand;
   logic             found;
   logic [NREQ-1:0]  gnt_nxt, done_nxt;
   logic             match_nxt, busy_nxt;
   logic [WIDTH-1:0] a_nxt, b_nxt;

   // search starts just past the last-served index and wraps
   always_comb begin
      win   = rr_ptr;
      found = 1'b0;
      cand  = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = PW'((int'(rr_ptr) + i) % NREQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      rr_nxt    = rr_ptr;
      gnt_nxt   = '0;
      done_nxt  = '0;
      match_nxt = match;
      busy_nxt  = 1'b0;
      a_nxt     = cmp_a;
      b_nxt     = cmp_b;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = EVAL;
               rr_nxt    = win;
               gnt_nxt   = NREQ'(1) << win;
               busy_nxt  = 1'b1;
               a_nxt     = a_in[win*WIDTH +: WIDTH];
               b_nxt     = b_in[win*WIDTH +: WIDTH];
            end
         end
         EVAL: begin
            state_nxt = IDLE;
            match_nxt = cmp_eq;
            done_nxt  = gnt;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         rr_ptr <= PW'(NREQ - 1);
         gnt    <= '0;
         done   <= '0;
         match  <= 1'b0;
         busy   <= 1'b0;
         cmp_a  <= '0;
         cmp_b  <= '0;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_nxt;
         gnt    <= gnt_nxt;
         done   <= done_nxt;
         match  <= match_nxt;
         busy   <= busy_nxt;
         cmp_a  <= a_nxt;
         cmp_b  <= b_nxt;
      end
   end

`ifdef COMP_ARB_STATS_EN
   // clear beats a coincident increment; both counters saturate
   always_ff @(posedge clk) begin
      if (!rst_n || stats_clr) begin
         cmp_cnt   <= '0;
         match_cnt <= '0;
      end else if (state == EVAL) begin
         if (cmp_cnt != 16'hFFFF)
            cmp_cnt <= cmp_cnt + 16'd1;
         if (cmp_eq && match_cnt != 16'hFFFF)
            match_cnt <= match_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: doc/comp_arb_ctrl.md
Name: comp_arb_ctrl

Overview:
- Round-robin arbiter and sequencer sharing one 8-bit equality comparator (comb. a==b -> eq) among NREQ requesters.
- Captures the winning requester's operands into registers that drive the shared comparator.
- Samples the comparator result one cycle later and returns it to the winner with a done pulse.
- Sits between requester blocks and the single comparator instance.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, operand width; must match the comparator width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
req  in  NREQ  per-requester compare request, level
a_in  in  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH]
b_in  in  NREQ*WIDTH  operand B, same packing as a_in
gnt  out  NREQ  one-hot; high for exactly the EVAL cycle of the winner
done  out  NREQ  one-hot, 1-cycle pulse; result valid for that requester
match  out  1  result of the last compare; 1 = operands equal
cmp_a  out  WIDTH  registered operand A to the shared comparator
cmp_b  out  WIDTH  registered operand B to the shared comparator
cmp_eq  in  1  comparator equality output (combinational from cmp_a/cmp_b)
busy  out  1  high while state = EVAL

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-low, on rst_n.
- All outputs are registered.
- Reset values: gnt=0, done=0, match=0, cmp_a=0, cmp_b=0, busy=0, state=IDLE, rr_ptr=NREQ-1 (last-served index).

FSM IDLE:
- If no req bit is set, stay in IDLE.
- Otherwise, choose the winner w: the first set req bit searching from index rr_ptr+1 upward, modulo NREQ.
- At the clock edge: cmp_a <= a_in[w], cmp_b <= b_in[w], gnt <= onehot(w), rr_ptr <= w, busy <= 1, state -> EVAL.

FSM EVAL:
- cmp_a and cmp_b are stable; cmp_eq is valid within this cycle.
- At the clock edge: match <= cmp_eq, done <= onehot(w), gnt <= 0, busy <= 0, state -> IDLE.
- No arbitration takes place in EVAL.

Latency and throughput:
- A req sampled in IDLE at edge N gives gnt high in cycle N+1 and done/match valid in cycle N+2.
- Maximum throughput is one compare every 2 cycles.

Handshake:
- A requester holds req, a_in and b_in stable until it observes gnt.
- Operands are sampled only at the IDLE->EVAL edge; changes after that edge are ignored.
- The requester drops req in the cycle after gnt unless it wants another compare.
- A req still high in the IDLE cycle carrying done counts as a new request.
- match holds its value until the next EVAL->IDLE edge.
- done and gnt are never set for two requesters at once.

Boundary cases:
- All requests asserted: strict rotation, each requester served once per NREQ compares. No starvation; worst-case wait is 2*NREQ cycles.
- Pointer wrap: rr_ptr=NREQ-1 makes index 0 highest priority.
- A requester that drops req in the same cycle it would win is not granted; arbitration uses the sampled req only.
- rst_n low in EVAL: the compare is abandoned, no done is issued, all outputs go to reset values at that edge.
- rst_n has priority over every other event.
- Unused high req bits when NREQ < 8 do not exist. Width follows NREQ exactly.

Optional Feature:
Macro COMP_ARB_STATS_EN.
- Defined: adds outputs cmp_cnt[15:0] and match_cnt[15:0].
  - cmp_cnt increments on every EVAL->IDLE edge.
  - match_cnt increments on that edge when cmp_eq=1.
  - Both saturate at 16'hFFFF and clear on reset.
  - Adds input stats_clr (1 bit, synchronous). It clears both counters; when it coincides with an increment, the clear wins.
- Not defined: these ports and registers are absent. The remaining behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req=4'b1111 -> gnt=0, done=0, match=0, cmp_a=cmp_b=0, busy=0 throughout.
- Single request: req=4'b0001, a_in[0]=8'h5A, b_in[0]=8'h5A at edge N -> gnt=4'b0001 in cycle N+1, cmp_a=cmp_b=8'h5A, done=4'b0001 and match=1 in cycle N+2. Repeat with b_in[0]=8'h5B -> match=0.
- Round-robin: req=4'b1111 held, each operand pair unique -> grant order 0,1,2,3,0, gnt spaced 2 cycles apart, each match equal to the reference compare of that requester's pair.
- Operand change after grant: requester 2 changes a_in from 8'h10 to 8'h11 in its gnt cycle, with b_in=8'h10 -> match=1 (captured operands used).
- Reset mid-compare: rst_n=0 in EVAL for requester 1 -> no done pulse. After release, with req=4'b0010, requester 1 is granted first (rr_ptr=3).
- COMP_ARB_STATS_EN: 5 compares, 3 of them equal -> cmp_cnt=5, match_cnt=3. Assert stats_clr coincident with a 6th compare -> both counters 0.
